// File: rtl/next_hop_scheduler_if.sv
// Request/response and neighbor-table signals of the next-hop scheduler.
// The master view belongs to the environment: the routing/MAC control that
// issues requests and the neighbor-table RAM that answers reads. The slave
// view belongs to the scheduler itself.
interface next_hop_scheduler_if #(
  parameter int unsigned ID_W   = 8,
  parameter int unsigned HOP_W  = 8,
  parameter int unsigned Q_W    = 16,
  parameter int unsigned ADDR_W = 5
) ();

  // Request side
  logic              start;
  logic [HOP_W-1:0]  my_hops_sink;
  logic [HOP_W-1:0]  my_hops_ch;
  logic [ID_W-1:0]   chosen_ch;
  logic [ADDR_W:0]   num_nbrs;

  // Neighbor-table read port
  logic              nbr_rd_en;
  logic [ADDR_W-1:0] nbr_addr;
  logic [ID_W-1:0]   nbr_id;
  logic [HOP_W-1:0]  nbr_hops_ch;
  logic [Q_W-1:0]    nbr_qvalue;

  // Result side
  logic              busy;
  logic              done;
  logic              found;
  logic [ID_W-1:0]   next_hop;

  modport master (
    output start, my_hops_sink, my_hops_ch, chosen_ch, num_nbrs,
    output nbr_id, nbr_hops_ch, nbr_qvalue,
    input  nbr_rd_en, nbr_addr,
    input  busy, done, found, next_hop
  );

  modport slave (
    input  start, my_hops_sink, my_hops_ch, chosen_ch, num_nbrs,
    input  nbr_id, nbr_hops_ch, nbr_qvalue,
    output nbr_rd_en, nbr_addr,
    output busy, done, found, next_hop
  );

endinterface

// File: rtl/next_hop_scheduler.sv
// Next-hop decision engine for an EER-RL clustered sensor node.
// Sink and cluster-head shortcuts resolve directly; otherwise the neighbor
// table is walked one entry per cycle and the highest-Q neighbor one hop
// closer to the cluster head is selected (lowest address wins ties).
module next_hop_scheduler #(
  parameter int unsigned     ID_W    = 8,
  parameter int unsigned     HOP_W   = 8,
  parameter int unsigned     Q_W     = 16,
  parameter int unsigned     ADDR_W  = 5,
  parameter logic [ID_W-1:0] SINK_ID = '0,
  parameter logic [ID_W-1:0] NO_HOP  = '1
) (
  input logic                 clk,
  input logic                 nrst,
  next_hop_scheduler_if.slave bus
);

  localparam int unsigned CntW = ADDR_W + 1;

  typedef enum logic [1:0] {
    StIdle,
    StDecide,
    StScan,
    StDone
  } state_e;

  state_e state_q, state_d;

  // Latched request
  logic [HOP_W-1:0] hops_sink_q, hops_sink_d;
  logic [HOP_W-1:0] hops_ch_q, hops_ch_d;
  logic [ID_W-1:0]  ch_id_q, ch_id_d;
  logic [CntW-1:0]  num_q, num_d;

  // Scan bookkeeping; the counter is one bit wider so a full table never wraps
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [CntW-1:0]  cnt_inc;
  logic             rd_en_q, rd_en_d;
  logic             eval_q;
  logic [Q_W-1:0]   qbest_q, qbest_d;
  logic [ID_W-1:0]  best_id_q, best_id_d;
  logic             have_cand_q, have_cand_d;
  logic [HOP_W-1:0] hop_tgt;
  logic             qualify;

  // Registered outputs
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             found_q, found_d;
  logic [ID_W-1:0]  next_hop_q, next_hop_d;

  assign cnt_inc = cnt_q + CntW'(1);
  assign hop_tgt = hops_ch_q - HOP_W'(1);
  // Read data is valid the cycle after a strobe, hence eval_q gating
  assign qualify = eval_q && (bus.nbr_hops_ch == hop_tgt);

  // State and datapath registers
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= StIdle;
      hops_sink_q <= '0;
      hops_ch_q   <= '0;
      ch_id_q     <= '0;
      num_q       <= '0;
      cnt_q       <= '0;
      rd_en_q     <= 1'b0;
      eval_q      <= 1'b0;
      qbest_q     <= '0;
      best_id_q   <= '0;
      have_cand_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      found_q     <= 1'b0;
      next_hop_q  <= NO_HOP;
    end else begin
      state_q     <= state_d;
      hops_sink_q <= hops_sink_d;
      hops_ch_q   <= hops_ch_d;
      ch_id_q     <= ch_id_d;
      num_q       <= num_d;
      cnt_q       <= cnt_d;
      rd_en_q     <= rd_en_d;
      eval_q      <= rd_en_q;
      qbest_q     <= qbest_d;
      best_id_q   <= best_id_d;
      have_cand_q <= have_cand_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      found_q     <= found_d;
      next_hop_q  <= next_hop_d;
    end
  end

  // Next-state, request latching, candidate selection and result formation
  always_comb begin
    state_d     = state_q;
    hops_sink_d = hops_sink_q;
    hops_ch_d   = hops_ch_q;
    ch_id_d     = ch_id_q;
    num_d       = num_q;
    cnt_d       = cnt_q;
    rd_en_d     = 1'b0;
    qbest_d     = qbest_q;
    best_id_d   = best_id_q;
    have_cand_d = have_cand_q;
    done_d      = 1'b0;
    found_d     = found_q;
    next_hop_d  = next_hop_q;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          hops_sink_d = bus.my_hops_sink;
          hops_ch_d   = bus.my_hops_ch;
          ch_id_d     = bus.chosen_ch;
          num_d       = bus.num_nbrs;
          state_d     = StDecide;
        end
      end

      StDecide: begin
        if (hops_sink_q == HOP_W'(1)) begin
          next_hop_d = SINK_ID;
          found_d    = 1'b1;
          done_d     = 1'b1;
          state_d    = StDone;
        end else if (hops_ch_q == HOP_W'(1)) begin
          next_hop_d = ch_id_q;
          found_d    = 1'b1;
          done_d     = 1'b1;
          state_d    = StDone;
        end else if ((hops_ch_q == '0) || (num_q == '0)) begin
          next_hop_d = NO_HOP;
          found_d    = 1'b0;
          done_d     = 1'b1;
          state_d    = StDone;
        end else begin
          have_cand_d = 1'b0;
          qbest_d     = '0;
          cnt_d       = '0;
          rd_en_d     = 1'b1;
          state_d     = StScan;
        end
      end

      StScan: begin
        // First qualifier always taken; later ones only on strictly higher Q
        if (qualify && (!have_cand_q || (bus.nbr_qvalue > qbest_q))) begin
          have_cand_d = 1'b1;
          qbest_d     = bus.nbr_qvalue;
          best_id_d   = bus.nbr_id;
        end
        if (rd_en_q) begin
          if (cnt_inc < num_q) begin
            cnt_d   = cnt_inc;
            rd_en_d = 1'b1;
          end
        end else begin
          // Trailing cycle: last entry evaluated above, publish result
          next_hop_d = have_cand_d ? best_id_d : NO_HOP;
          found_d    = have_cand_d;
          done_d     = 1'b1;
          state_d    = StDone;
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase

    busy_d = (state_d != StIdle);
  end

  assign bus.nbr_rd_en = rd_en_q;
  assign bus.nbr_addr  = cnt_q[ADDR_W-1:0];
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.found     = found_q;
  assign bus.next_hop  = next_hop_q;

endmodule

// File: doc/next_hop_scheduler.md
Name: next_hop_scheduler

Overview:
- Sequential controller that runs one next-hop decision per request for a sensor node in the EER-RL clustered routing layer.
- Sink and cluster-head shortcuts resolve without a table access. Otherwise the block walks the neighbor table over a synchronous read port, one entry per cycle.
- Among neighbors whose hops-to-CH equals own hops-to-CH minus 1, it selects the one with the highest Q-value.
- Sits between the node's routing/MAC control logic and the neighbor-table RAM.

Parameters:
- ID_W, 8, node ID width.
- HOP_W, 8, hop-count width.
- Q_W, 16, Q-value width (unsigned).
- ADDR_W, 5, neighbor-table address width (table depth 2^ADDR_W).
- SINK_ID, 8'h00, ID driven when the node is one hop from the sink.
- NO_HOP, 8'hFF, ID driven when no valid next hop exists.

Ports:
- clk  in  1  single clock, rising edge.
- nrst  in  1  asynchronous active-low reset.
- start  in  1  request pulse; sampled only in IDLE.
- my_hops_sink  in  HOP_W  own hop count to sink; latched on start.
- my_hops_ch  in  HOP_W  own hop count to chosen CH; latched on start.
- chosen_ch  in  ID_W  chosen cluster head ID; latched on start.
- num_nbrs  in  ADDR_W+1  valid table entries (0..2^ADDR_W); latched on start.
- nbr_rd_en  out  1  table read strobe.
- nbr_addr  out  ADDR_W  table read address.
- nbr_id  in  ID_W  entry node ID; valid the cycle after nbr_rd_en.
- nbr_hops_ch  in  HOP_W  entry hops to CH; same timing as nbr_id.
- nbr_qvalue  in  Q_W  entry Q-value; same timing as nbr_id.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the result is valid.
- found  out  1  1 when next_hop is a real destination.
- next_hop  out  ID_W  selected next hop; held until the next done.

Behaviour:
- Reset (nrst low, asynchronous):
  - state = IDLE.
  - busy, done, found, nbr_rd_en = 0.
  - nbr_addr = 0; next_hop = NO_HOP.
  - Internal best_q = 0, have_cand = 0.
  - Reset mid-scan aborts with no done pulse.
- FSM states: IDLE, DECIDE, SCAN, DONE.
- IDLE:
  - On start=1: latch all request inputs and go to DECIDE.
  - start in any other state is ignored; there is no queueing.
- DECIDE (one cycle), priority order:
  - my_hops_sink==1: result SINK_ID, found=1.
  - else my_hops_ch==1: result chosen_ch, found=1.
  - else my_hops_ch==0 or num_nbrs==0: result NO_HOP, found=0.
  - else: clear have_cand and best_q, then go to SCAN.
  - The first three cases go to DONE.
- SCAN:
  - Read issue runs for num_nbrs cycles: nbr_rd_en=1, nbr_addr = 0,1,…,num_nbrs-1.
  - One extra trailing cycle follows with nbr_rd_en=0 to evaluate the last entry.
  - The SCAN state therefore lasts num_nbrs+1 cycles.
  - Address counter is ADDR_W+1 bits internally, so num_nbrs=2^ADDR_W has no wrap; nbr_addr is its low ADDR_W bits.
- Candidate rule, applied to each returned entry:
  - Entry qualifies when nbr_hops_ch == my_hops_ch-1 (exact HOP_W compare; my_hops_ch≥2 is guaranteed here).
  - The first qualifying entry is always accepted, including Q=0.
  - A later qualifying entry replaces the stored best only if its Q is strictly greater.
  - On a tie, the lowest address wins.
- End of SCAN:
  - have_cand=1: result is the stored ID, found=1.
  - have_cand=0: result NO_HOP, found=0.
  - Then go to DONE.
- DONE (one cycle):
  - done=1; next_hop and found are registered and updated on entry to DONE.
  - Then return to IDLE.
  - A start asserted during DONE is ignored.
- Latency:
  - start sampled at cycle 0.
  - Shortcut paths: done at cycle 2.
  - Scan path: done at cycle num_nbrs+3.
- Outputs are all registered; there is no combinational path from input to output.

Test Plan:
- Sink shortcut: start with my_hops_sink=1, my_hops_ch=1 → done at cycle 2, next_hop=8'h00, found=1, nbr_rd_en never asserted.
- CH shortcut: my_hops_sink=3, my_hops_ch=1, chosen_ch=8'h17 → done at cycle 2, next_hop=8'h17, found=1.
- Scan select: my_hops_sink=4, my_hops_ch=3, num_nbrs=4, table {ID 5: hops 2, Q 100; ID 6: hops 1, Q 900; ID 7: hops 2, Q 300; ID 8: hops 2, Q 300} → addresses 0..3 issued on consecutive cycles, done at cycle 7, next_hop=7, found=1.
- No candidate / Q=0: same setup, all entries hops_ch=3 → next_hop=8'hFF, found=0. Single qualifying entry with Q=0, ID 9 → next_hop=9, found=1.
- Boundaries: num_nbrs=0 → done at cycle 2, NO_HOP. num_nbrs=32 with best at address 31 → done at cycle 35, last nbr_addr=31, selected correctly.
- Control hazards: start pulses during SCAN and DONE are ignored with exactly one done per request. nrst dropped mid-SCAN → outputs return to reset values immediately, no done. A fresh start afterwards completes normally.
